// File: rtl/matrix_pkg.sv
// Shared definitions for the 2x2 matrix adder datapath.
//   ELEM_W / N_ELEM : operand element width and elements per operand pair
//   SUM_W           : adder result width (one carry bit above ELEM_W)
//   IDX_*           : serial arrival index of each element (A row-major, then B)
//   loader_state_t  : operand loader FSM states
package matrix_pkg;

    localparam int ELEM_W = 3;
    localparam int N_ELEM = 8;
    localparam int SUM_W  = ELEM_W + 1;
    localparam int CNT_W  = $clog2(N_ELEM);

    localparam int IDX_A11 = 0;
    localparam int IDX_A12 = 1;
    localparam int IDX_A21 = 2;
    localparam int IDX_A22 = 3;
    localparam int IDX_B11 = 4;
    localparam int IDX_B12 = 5;
    localparam int IDX_B21 = 6;
    localparam int IDX_B22 = 7;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/operand_reg_bank.sv
// Eight element registers with a single indexed write port.
//   clk, rst : clock and synchronous active-high reset (clears all elements)
//   wr_en    : write strobe
//   wr_idx   : element index to write
//   wr_data  : element value
//   elems    : all element registers in parallel, elems[i] is index i
module operand_reg_bank #(
    parameter int ELEM_W = matrix_pkg::ELEM_W,
    parameter int N_ELEM = matrix_pkg::N_ELEM,
    parameter int IDX_W  = $clog2(N_ELEM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [ELEM_W-1:0]              wr_data,
    output logic [N_ELEM-1:0][ELEM_W-1:0]  elems
);

    logic [N_ELEM-1:0]              sel;
    logic [N_ELEM-1:0][ELEM_W-1:0]  elem_reg;

    // One-hot decode of the write index.
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_sel
            assign sel[gi] = wr_en && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_reg <= '0;
        end else begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (sel[i]) begin
                    elem_reg[i] <= wr_data;
                end
            end
        end
    end

    assign elems = elem_reg;

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader for the 2x2 matrix adder.
// Collects eight elements (a11,a12,a21,a22,b11,b12,b21,b22) over a
// valid/ready stream and presents them in parallel with a valid/ready
// handshake. The pair is held stable until accepted or dropped by clear/rst.
//   clk, rst            : clock, synchronous active-high reset
//   clear               : synchronous abort of a partial load or held pair
//   in_valid/in_data    : element stream input
//   in_ready            : high while loading (decoded from state only)
//   out_valid/out_ready : operand pair handshake
//   a11..b22            : operand elements
//   load_count          : elements captured so far in the current load
module matrix_operand_loader #(
    parameter int ELEM_W = matrix_pkg::ELEM_W,
    parameter int N_ELEM = matrix_pkg::N_ELEM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic [ELEM_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ELEM_W-1:0]           a11,
    output logic [ELEM_W-1:0]           a12,
    output logic [ELEM_W-1:0]           a21,
    output logic [ELEM_W-1:0]           a22,
    output logic [ELEM_W-1:0]           b11,
    output logic [ELEM_W-1:0]           b12,
    output logic [ELEM_W-1:0]           b21,
    output logic [ELEM_W-1:0]           b22,
    output logic [$clog2(N_ELEM)-1:0]   load_count
);

    import matrix_pkg::*;

    localparam int IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    loader_state_t                  state_reg, state_next;
    logic [IDX_W-1:0]               count_reg, count_next;
    logic                           accept;
    logic [N_ELEM-1:0][ELEM_W-1:0]  elems;

    // Handshake outputs come from state alone, so no input-to-output path.
    assign in_ready   = (state_reg == LOAD);
    assign out_valid  = (state_reg == FULL);
    assign load_count = count_reg;

    // clear beats an element offered in the same cycle.
    assign accept = in_valid && (state_reg == LOAD) && !clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (clear) begin
            // Drops a partial load or a held pair, even if out_ready is high.
            state_next = LOAD;
            count_next = '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (in_valid) begin
                        if (count_reg == LAST_IDX) begin
                            state_next = FULL;
                            count_next = '0;
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_next = LOAD;
                    end
                end
                default: begin
                    state_next = LOAD;
                    count_next = '0;
                end
            endcase
        end
    end

    operand_reg_bank #(
        .ELEM_W (ELEM_W),
        .N_ELEM (N_ELEM),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_idx  (count_reg),
        .wr_data (in_data),
        .elems   (elems)
    );

    assign a11 = elems[IDX_A11];
    assign a12 = elems[IDX_A12];
    assign a21 = elems[IDX_A21];
    assign a22 = elems[IDX_A22];
    assign b11 = elems[IDX_B11];
    assign b12 = elems[IDX_B12];
    assign b21 = elems[IDX_B21];
    assign b22 = elems[IDX_B22];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader: a table of operand pairs
// is streamed in, expected pairs go to a scoreboard queue, and a monitor
// pops and compares each pair at its handshake. Hand-written sequences
// cover back-pressure, clear and reset corner cases.
module tb_matrix_operand_loader;

    import matrix_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic                 in_valid;
    logic [ELEM_W-1:0]    in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [ELEM_W-1:0]    a11, a12, a21, a22, b11, b12, b21, b22;
    logic [CNT_W-1:0]     load_count;

    int errors = 0;
    int checks = 0;
    int pairs_seen = 0;

    typedef struct packed {
        logic [7:0][ELEM_W-1:0] e;   // e[0] = a11 ... e[7] = b22
        logic [3:0][SUM_W-1:0]  c;   // c11, c12, c21, c22
    } pair_t;

    typedef struct packed {
        pair_t p;
        int    gap;
        int    hold;
    } vec_t;

    vec_t  vecs [4];
    pair_t sb_q [$];
    pair_t exp_p;
    logic [7:0][ELEM_W-1:0] got;
    logic [SUM_W-1:0] sum;

    matrix_operand_loader dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a11        (a11),
        .a12        (a12),
        .a21        (a21),
        .a22        (a22),
        .b11        (b11),
        .b12        (b12),
        .b21        (b21),
        .b22        (b22),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_elems();
        return 32'({b22, b21, b12, b11, a22, a21, a12, a11});
    endfunction

    task automatic set_vec(input int idx,
                           input int e0, input int e1, input int e2, input int e3,
                           input int e4, input int e5, input int e6, input int e7,
                           input int c0, input int c1, input int c2, input int c3,
                           input int gap, input int hold);
        vecs[idx].p.e[0] = ELEM_W'(e0);
        vecs[idx].p.e[1] = ELEM_W'(e1);
        vecs[idx].p.e[2] = ELEM_W'(e2);
        vecs[idx].p.e[3] = ELEM_W'(e3);
        vecs[idx].p.e[4] = ELEM_W'(e4);
        vecs[idx].p.e[5] = ELEM_W'(e5);
        vecs[idx].p.e[6] = ELEM_W'(e6);
        vecs[idx].p.e[7] = ELEM_W'(e7);
        vecs[idx].p.c[0] = SUM_W'(c0);
        vecs[idx].p.c[1] = SUM_W'(c1);
        vecs[idx].p.c[2] = SUM_W'(c2);
        vecs[idx].p.c[3] = SUM_W'(c3);
        vecs[idx].gap    = gap;
        vecs[idx].hold   = hold;
    endtask

    // Scoreboard monitor: a handshake happens at the next rising edge when
    // out_valid && out_ready with no clear/rst, so compare on the falling edge.
    always @(negedge clk) begin
        if (!rst && !clear && out_valid && out_ready) begin
            got = {b22, b21, b12, b11, a22, a21, a12, a11};
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pair with a11=%0d, expected no pair", a11);
            end else begin
                exp_p = sb_q.pop_front();
                for (int i = 0; i < 8; i++) begin
                    check($sformatf("sb_elem%0d", i), 32'(got[i]), 32'(exp_p.e[i]));
                end
                for (int i = 0; i < 4; i++) begin
                    sum = SUM_W'(got[i]) + SUM_W'(got[i + 4]);
                    check($sformatf("sb_sum%0d", i), 32'(sum), 32'(exp_p.c[i]));
                end
                $display("pair %0d: a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d", pairs_seen,
                         a11, a12, a21, a22, b11, b12, b21, b22);
                pairs_seen++;
            end
        end
    end

    // All tasks start and end at one time unit after a rising edge.
    task automatic load_elems(input logic [7:0][ELEM_W-1:0] e, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = e[i];
            @(negedge clk);
            check("in_ready_load", 32'(in_ready), 32'd1);
            check("load_count_step", 32'(load_count), 32'(i));
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                in_data = ELEM_W'($urandom_range(0, 7));
                @(posedge clk); #1;
            end
        end
        in_data = '0;
    endtask

    task automatic run_vector(input vec_t v);
        sb_q.push_back(v.p);
        load_elems(v.p.e, 8, v.gap);
        @(negedge clk);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_load_count", 32'(load_count), 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = ELEM_W'(h);
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_load_count", 32'(load_count), 32'd0);
            check("hold_elems", all_elems(), 32'(v.p.e));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        //      idx  a11 a12 a21 a22 b11 b12 b21 b22   c11 c12 c21 c22  gap hold
        set_vec(0,   1,  2,  3,  4,  5,  6,  7,  0,    6,  8, 10,  4,   0, 20);
        set_vec(1,   7,  7,  7,  7,  7,  7,  7,  7,   14, 14, 14, 14,   2,  0);
        set_vec(2,   0,  1,  2,  3,  4,  5,  6,  7,    4,  6,  8, 10,   1,  3);
        set_vec(3,   5,  3,  6,  2,  1,  4,  7,  7,    6,  7, 13,  9,   0,  1);

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_elems", all_elems(), 32'd0);
        @(posedge clk); #1;

        // Table: back-pressure on vector 0, gapped input on vector 1.
        for (int v = 0; v < 2; v++) begin
            run_vector(vecs[v]);
        end

        // Clear after 5 accepts, clear coincident with an offered element.
        load_elems(vecs[1].p.e, 5, 0);
        @(negedge clk);
        check("pre_clear_count", 32'(load_count), 32'd5);
        @(posedge clk); #1;
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'd5;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("clear_load_count", 32'(load_count), 32'd0);
        check("clear_out_valid", 32'(out_valid), 32'd0);
        check("clear_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        run_vector(vecs[2]);

        // Clear in FULL with out_ready high: pair dropped, not transferred.
        load_elems(vecs[3].p.e, 8, 0);
        @(negedge clk);
        check("cfull_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        clear     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clear     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("cfull_out_valid_after", 32'(out_valid), 32'd0);
        check("cfull_load_count", 32'(load_count), 32'd0);
        check("cfull_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        run_vector(vecs[3]);

        // Reset mid-load at load_count=6.
        load_elems(vecs[0].p.e, 6, 0);
        @(negedge clk);
        check("pre_rst_count", 32'(load_count), 32'd6);
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'd3;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst6_in_ready", 32'(in_ready), 32'd1);
        check("rst6_out_valid", 32'(out_valid), 32'd0);
        check("rst6_load_count", 32'(load_count), 32'd0);
        check("rst6_elems", all_elems(), 32'd0);
        @(posedge clk); #1;

        // Reset in FULL with out_ready high.
        load_elems(vecs[1].p.e, 8, 0);
        @(negedge clk);
        check("rfull_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rfull_in_ready", 32'(in_ready), 32'd1);
        check("rfull_out_valid_after", 32'(out_valid), 32'd0);
        check("rfull_load_count", 32'(load_count), 32'd0);
        check("rfull_elems", all_elems(), 32'd0);
        @(posedge clk); #1;

        check("sb_pairs_delivered", 32'(pairs_seen), 32'd4);
        check("sb_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream stage of the 2x2 matrix adder: accepts matrix elements one at a time over a valid/ready stream, assembles a complete operand pair (matrix A and matrix B, eight 3-bit elements), and presents all eight in parallel to the combinational adder with a valid/ready handshake. It turns a narrow serial source (UART shim, testbench driver, switch bank) into the parallel operand bus the adder consumes. The operand bus is held stable until the consumer accepts it.

## Interface
Parameters:
- ELEM_W, 3, element width in bits; must match the adder's operand width.
- N_ELEM, 8, elements per operand pair; fixed at 8 (four for A, four for B).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort; discards a partial load.
- in_valid  in  1  producer has an element on in_data.
- in_data  in  ELEM_W  element value.
- in_ready  out  1  loader can take an element this cycle.
- out_valid  out  1  a complete operand pair is on the A/B outputs.
- out_ready  in  1  adder-side consumer accepts the pair.
- a11, a12, a21, a22  out  ELEM_W each  matrix A elements.
- b11, b12, b21, b22  out  ELEM_W each  matrix B elements.
- load_count  out  3  number of elements captured in the current load (0..7).

## Operation
- Element order, index 0..7: a11, a12, a21, a22, b11, b12, b21, b22 (A row-major, then B row-major).
- FSM states:
  - LOAD: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Accept: an element is accepted on the rising edge when in_valid && in_ready. It is written to the register selected by load_count, and load_count increments.
- LOAD -> FULL: taken on the accept of index 7. load_count wraps to 0 on that edge.
- FULL -> LOAD: taken on the edge where out_valid && out_ready. Element registers keep their values; they are overwritten by the next load.
- In FULL, in_valid is ignored and in_data is not sampled.
- clear in LOAD: load_count becomes 0 and the state stays LOAD. An element presented in the same cycle is discarded, because clear has priority over accept.
- clear in FULL: the held pair is dropped, the state goes to LOAD and load_count becomes 0. This happens even if out_ready is high that cycle; the consumer must treat the pair as not transferred.
- rst has priority over clear and over all handshakes.
- No arithmetic is performed. Values pass through unmodified at ELEM_W bits, with no sign interpretation.

## Timing
- Reset values:
  - state LOAD
  - in_ready=1
  - out_valid=0
  - load_count=0
  - all eight element outputs 0
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output; in particular, in_ready does not depend on out_ready.
- Latency: index 7 accepted at edge N -> out_valid=1 in the cycle after edge N. The minimum load is 8 cycles, so the best-case throughput is one pair per 9 cycles (8 loads plus 1 handoff).
- Element outputs update only on an accept of the matching index. They are stable for the whole time out_valid=1.
- out_valid stays high until the handshake completes or clear/rst is asserted. Back-pressure of any length is legal.
- Reset mid-load (rst at any load_count) returns to the reset values on the next edge, and partial data is lost.

## Structure
- Shared package (matrix_pkg):
  - ELEM_W and N_ELEM constants.
  - Element-index localparams IDX_A11..IDX_B22.
  - Loader state enum {LOAD, FULL}.
  - The adder's result width constant (ELEM_W+1) belongs here too.
- Sub-module:
  - operand_reg_bank: eight ELEM_W registers with an indexed write-enable, one per element.
  - The FSM and counter stay in the top module.

## Test plan
- After reset, stream 1,2,3,4,5,6,7,0 with in_valid held high -> out_valid rises the cycle after the 8th accept with a11=1, a12=2, a21=3, a22=4, b11=5, b12=6, b21=7, b22=0; in_ready=0 meanwhile; adder output c11=6, c12=8, c21=10, c22=4.
- Hold out_ready=0 for 20 cycles with in_valid=1 and in_data toggling -> outputs unchanged, in_ready=0, load_count=0. Then raise out_ready for 1 cycle -> out_valid=0 and in_ready=1 the next cycle.
- Gapped input: in_valid pulsed every 3rd cycle with 7,7,7,7,7,7,7,7 -> out_valid appears one cycle after the 8th pulse; all elements 7; adder gives 14 on every output.
- Assert clear after 5 accepts (load_count=5), then load 0,1,2,3,4,5,6,7 -> a11=0 and b22=7, i.e. the partial data was discarded; clear coincident with an accept leaves load_count=0.
- Assert clear in FULL with out_ready=1 in the same cycle -> LOAD next cycle, out_valid=0, load_count=0.
- Assert rst at load_count=6 and in FULL -> next cycle in_ready=1, out_valid=0, load_count=0, all element outputs 0.
